// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes size/sign from funct3, issues one memory access
// per request and returns an extended load result or a misalign/fault response.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_misalign,
  output logic        resp_fault
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [7:0]  wait_cnt;

  logic        legal;
  logic        misalign;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;

  assign req_ready = (state == IDLE);

  always_comb begin
    legal = 1'b0;
    if (req_we) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end

    misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    case (funct3[1:0])
      2'b00:   be_n = 4'b0001 << addr[1:0];
      2'b01:   be_n = addr[1] ? 4'b1100 : 4'b0011;
      default: be_n = 4'b1111;
    endcase

    wdata_n = '0;
    if (req_we) begin
      case (funct3[1:0])
        2'b00:   wdata_n = {4{wdata[7:0]}};
        2'b01:   wdata_n = {2{wdata[15:0]}};
        default: wdata_n = wdata;
      endcase
    end
  end

  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_data = {{16{half_v[15]}}, half_v};
      3'b100:  load_data = {24'h0, byte_v};
      3'b101:  load_data = {16'h0, half_v};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      f3_q          <= '0;
      lane_q        <= '0;
      wait_cnt      <= '0;
      mem_valid     <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_misalign <= 1'b0;
      resp_fault    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q     <= funct3;
            lane_q   <= addr[1:0];
            wait_cnt <= '0;
            if (!legal || misalign) begin
              // Illegal encoding dominates: misalign is reported only for legal requests.
              state         <= RESP;
              resp_valid    <= 1'b1;
              resp_data     <= '0;
              resp_fault    <= !legal;
              resp_misalign <= legal && misalign;
            end else begin
              state     <= ACCESS;
              mem_valid <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wdata_n;
            end
          end
        end
        ACCESS: begin
          // mem_ready is tested first so a completion on the last allowed cycle wins.
          if (mem_ready || (wait_cnt == 8'(MAX_WAIT - 1))) begin
            state         <= RESP;
            mem_valid     <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            resp_valid    <= 1'b1;
            resp_misalign <= 1'b0;
            resp_fault    <= !mem_ready;
            resp_data     <= (mem_ready && !mem_we) ? load_data : '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          state         <= IDLE;
          resp_valid    <= 1'b0;
          resp_data     <= '0;
          resp_misalign <= 1'b0;
          resp_fault    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
